stream_mux_rr: RTL and testbench

- Parametrised N-channel, W-bit streaming multiplexer; next generation of the team's structural 4:1 mux.
- Adds per-channel valid/ready handshakes, a registered output stage, and two selection modes:
  - manual select via sel;
  - fair round-robin scan.
- Sits between multiple producer streams and one consumer; merges them one beat per cycle with backpressure.

---
 rtl/stream_mux_rr.sv | 169 ++++++++++++++++
 tb/tb_stream_mux_rr.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel, W-bit stream multiplexer with valid/ready handshakes,
// a registered output stage, and manual or round-robin channel selection.
// Optional build macro STREAM_MUX_PARITY_EN adds a registered even-parity output
// (out_par) that tracks out_data.
module stream_mux_rr #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 8,
  parameter int unsigned SW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_ch
`ifdef STREAM_MUX_PARITY_EN
  ,
  output logic           out_par
`endif
);

  // Channel data unpacked once so the mux below is a plain indexed select.
  logic [W-1:0]  ch_data [N];

  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] out_ch_q, out_ch_d;
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;

  logic          load;
  logic          man_vld;
  logic          rr_vld;
  logic [SW-1:0] rr_idx;
  logic          grant_vld;
  logic [SW-1:0] grant_idx;
  logic [W-1:0]  grant_data;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*W +: W];
  end

  // The output register can take a new beat when empty or draining this cycle.
  assign load = ~out_valid_q | out_ready;

  // Manual grant: sel must name an existing channel that is valid.
  always_comb begin
    man_vld = 1'b0;
    for (int unsigned c = 0; c < N; c++) begin
      if (SW'(c) == sel && in_valid[c]) begin
        man_vld = 1'b1;
      end
    end
  end

  // Round-robin scan: first valid channel at or above rr_ptr, else first valid overall.
  always_comb begin
    logic found_hi;
    logic found_lo;
    logic [SW-1:0] idx_hi;
    logic [SW-1:0] idx_lo;
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int unsigned c = 0; c < N; c++) begin
      if (in_valid[c] && SW'(c) >= rr_ptr_q && !found_hi) begin
        found_hi = 1'b1;
        idx_hi   = SW'(c);
      end
      if (in_valid[c] && !found_lo) begin
        found_lo = 1'b1;
        idx_lo   = SW'(c);
      end
    end
    rr_vld = found_hi | found_lo;
    rr_idx = found_hi ? idx_hi : idx_lo;
  end

  // Mode selects which grant source is live this cycle.
  always_comb begin
    grant_vld = mode ? rr_vld : man_vld;
    grant_idx = mode ? rr_idx : sel;
  end

  // Data of the granted channel.
  always_comb begin
    grant_data = '0;
    for (int unsigned c = 0; c < N; c++) begin
      if (SW'(c) == grant_idx) begin
        grant_data = ch_data[c];
      end
    end
  end

  // One-hot ready to the granted producer; held low throughout reset.
  always_comb begin
    in_ready = '0;
    for (int unsigned c = 0; c < N; c++) begin
      in_ready[c] = ~rst & load & grant_vld & (SW'(c) == grant_idx);
    end
  end

  // Next state of the output stage and the round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      if (grant_vld) begin
        out_data_d  = grant_data;
        out_ch_d    = grant_idx;
        out_valid_d = 1'b1;
        // Explicit wrap so non-power-of-two N returns to channel 0.
        rr_ptr_d    = (32'(grant_idx) == N - 1) ? '0 : grant_idx + SW'(1);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Output stage and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

`ifdef STREAM_MUX_PARITY_EN
  logic out_par_q, out_par_d;

  // Parity follows the data register: updates only when a beat is accepted.
  always_comb begin
    out_par_d = out_par_q;
    if (load && grant_vld) begin
      out_par_d = ^grant_data;
    end
  end

  // Parity register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_par_q <= 1'b0;
    end else begin
      out_par_q <= out_par_d;
    end
  end

  assign out_par = out_par_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: a 4-channel and a 3-channel instance, a vector table,
// hand-written corner sequences and a randomized run against a queue-free model.
module tb_stream_mux_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [31:0] d4;
  logic [3:0]  v4, r4;
  logic        mode4, ov4, ordy4;
  logic [1:0]  sel4, och4;
  logic [7:0]  od4;

  logic [23:0] d3;
  logic [2:0]  v3, r3;
  logic        mode3, ov3, ordy3;
  logic [1:0]  sel3, och3;
  logic [7:0]  od3;

`ifdef STREAM_MUX_PARITY_EN
  logic par4, par3;
`endif

  stream_mux_rr #(.N(4), .W(8), .SW(2)) dut4 (
    .clk(clk), .rst(rst), .in_data(d4), .in_valid(v4), .in_ready(r4), .mode(mode4),
    .sel(sel4), .out_data(od4), .out_valid(ov4), .out_ready(ordy4), .out_ch(och4)
`ifdef STREAM_MUX_PARITY_EN
    , .out_par(par4)
`endif
  );

  stream_mux_rr #(.N(3), .W(8), .SW(2)) dut3 (
    .clk(clk), .rst(rst), .in_data(d3), .in_valid(v3), .in_ready(r3), .mode(mode3),
    .sel(sel3), .out_data(od3), .out_valid(ov3), .out_ready(ordy3), .out_ch(och3)
`ifdef STREAM_MUX_PARITY_EN
    , .out_par(par3)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("reset_out_valid4", 32'(ov4), 32'd0);
    chk("reset_ready4", 32'(r4), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reference model: state of one mux instance in specification terms.
  typedef struct {
    int         ptr;
    bit         ov;
    logic [7:0] data;
    int         ch;
    bit         par;
  } model_t;

  function automatic int grant_of(int n, bit md, int s, logic [15:0] valid, int ptr);
    if (!md) return (s < n && valid[s]) ? s : -1;
    for (int k = 0; k < n; k++) begin
      if (valid[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  function automatic logic [15:0] exp_rdy(int n, bit md, int s, logic [15:0] valid, bit ordy,
                                          model_t m);
    logic [15:0] r;
    int g;
    r = '0;
    g = grant_of(n, md, s, valid, m.ptr);
    if ((!m.ov || ordy) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic model_t next_state(int n, bit md, int s, logic [15:0] valid, bit ordy,
                                        logic [127:0] data, model_t m);
    model_t r;
    int g;
    logic [127:0] sh;
    r = m;
    if (m.ov && !ordy) return r;
    g = grant_of(n, md, s, valid, m.ptr);
    if (g < 0) begin
      r.ov = 1'b0;
    end else begin
      sh     = data >> (g * 8);
      r.ov   = 1'b1;
      r.data = sh[7:0];
      r.ch   = g;
      r.par  = ^sh[7:0];
      r.ptr  = (g + 1) % n;
    end
    return r;
  endfunction

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] exp_ready;
    logic       exp_ov;
    logic [7:0] exp_data;
    logic [1:0] exp_ch;
  } vec_t;

  vec_t   tbl [8];
  model_t m4, m3, e4, e3;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 8'hCC, 2'd2};
    tbl[1] = '{1'b0, 2'd0, 4'hE, 1'b1, 4'b0000, 1'b0, 8'hCC, 2'd2};
    tbl[2] = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 8'hDD, 2'd3};
    tbl[3] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 8'hDD, 2'd3};
    tbl[4] = '{1'b1, 2'd0, 4'h5, 1'b1, 4'b0001, 1'b1, 8'hAA, 2'd0};
    tbl[5] = '{1'b1, 2'd0, 4'h5, 1'b1, 4'b0100, 1'b1, 8'hCC, 2'd2};
    tbl[6] = '{1'b0, 2'd1, 4'h2, 1'b1, 4'b0010, 1'b1, 8'hBB, 2'd1};
    tbl[7] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 8'hBB, 2'd1};

    d4 = 32'hDDCCBBAA; v4 = 4'hF; mode4 = 1'b1; sel4 = 2'd0; ordy4 = 1'b1;
    d3 = 24'h332211;   v3 = 3'h7; mode3 = 1'b1; sel3 = 2'd0; ordy3 = 1'b1;
    rst = 1'b0;
    #2;

    // Reset values
    do_reset();
    chk("reset_out_data4", 32'(od4), 32'd0);
    chk("reset_out_ch4", 32'(och4), 32'd0);
    chk("reset_out_valid3", 32'(ov3), 32'd0);

    // Vector table from the reset state
    for (int i = 0; i < 8; i++) begin
      mode4 = tbl[i].mode; sel4 = tbl[i].sel; v4 = tbl[i].valid; ordy4 = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(r4), 32'(tbl[i].exp_ready));
      tick();
      chk($sformatf("tbl%0d_valid", i), 32'(ov4), 32'(tbl[i].exp_ov));
      chk($sformatf("tbl%0d_data", i), 32'(od4), 32'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_ch", i), 32'(och4), 32'(tbl[i].exp_ch));
    end

    // Round-robin fairness with all channels valid
    do_reset();
    mode4 = 1'b1; v4 = 4'hF; ordy4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_onehot", 32'($countones(r4)), 32'd1);
      chk("rr_ready", 32'(r4), 32'(1 << (i % 4)));
      tick();
      chk("rr_ch", 32'(och4), 32'(i % 4));
    end

    // Backpressure: last beat was channel 1, pointer now 2
    ordy4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 32'(r4), 32'd0);
      tick();
      chk("bp_data", 32'(od4), 32'hBB);
      chk("bp_valid", 32'(ov4), 32'd1);
    end
    ordy4 = 1'b1;
    #1;
    chk("bp_release_ready", 32'(r4), 32'b0100);
    tick();
    chk("bp_release_data", 32'(od4), 32'hCC);

    // Sparse round-robin: grant channel 1 manually so the pointer lands on 2
    mode4 = 1'b0; sel4 = 2'd1; v4 = 4'b0010;
    tick();
    mode4 = 1'b1; v4 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sparse_ch", 32'(och4), (i % 2 == 0) ? 32'd3 : 32'd1);
    end
    v4 = 4'h0;
    tick();
    chk("sparse_idle_valid", 32'(ov4), 32'd0);

    // Asynchronous reset mid-cycle while a beat is pending
    v4 = 4'hF; ordy4 = 1'b0;
    tick();
    chk("pre_reset_valid", 32'(ov4), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(ov4), 32'd0);
    chk("async_rst_data", 32'(od4), 32'd0);
    chk("async_rst_ch", 32'(och4), 32'd0);
    chk("async_rst_ready", 32'(r4), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ordy4 = 1'b1;
    #1;
    chk("post_rst_ready", 32'(r4), 32'b0001);
    tick();
    chk("post_rst_ch", 32'(och4), 32'd0);
    chk("post_rst_data", 32'(od4), 32'hAA);

    // N = 3: wrap 2 -> 0, and sel = 3 never grants
    do_reset();
    mode3 = 1'b1; v3 = 3'h7; ordy3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("n3_ch", 32'(och3), 32'(i % 3));
      chk("n3_data", 32'(od3), 32'(8'h11 * ((i % 3) + 1)));
    end
    mode3 = 1'b0; sel3 = 2'd3;
    #1;
    chk("n3_sel3_ready", 32'(r3), 32'd0);
    tick();
    chk("n3_sel3_valid", 32'(ov3), 32'd0);

    // Parity of accepted data
    mode4 = 1'b0; sel4 = 2'd0; v4 = 4'b0001; ordy4 = 1'b1; d4 = 32'h000000A5;
    tick();
    chk("par_a5_data", 32'(od4), 32'hA5);
`ifdef STREAM_MUX_PARITY_EN
    chk("par_a5", 32'(par4), 32'd0);
`endif
    d4 = 32'h00000007;
    tick();
    chk("par_07_data", 32'(od4), 32'h07);
`ifdef STREAM_MUX_PARITY_EN
    chk("par_07", 32'(par4), 32'd1);
`endif

    // Randomized run against the model on both instances
    do_reset();
    m4 = '{0, 1'b0, 8'h00, 0, 1'b0};
    m3 = '{0, 1'b0, 8'h00, 0, 1'b0};
    for (int it = 0; it < 400; it++) begin
      mode4 = 1'($urandom); sel4 = 2'($urandom); v4 = 4'($urandom);
      ordy4 = ($urandom % 4) != 0; d4 = $urandom;
      mode3 = 1'($urandom); sel3 = 2'($urandom); v3 = 3'($urandom);
      ordy3 = ($urandom % 4) != 0; d3 = 24'($urandom);
      #1;
      chk("rand4_ready", 32'(r4),
          32'(exp_rdy(4, mode4, int'(sel4), 16'(v4), ordy4, m4)));
      chk("rand3_ready", 32'(r3),
          32'(exp_rdy(3, mode3, int'(sel3), 16'(v3), ordy3, m3)));
      e4 = next_state(4, mode4, int'(sel4), 16'(v4), ordy4, 128'(d4), m4);
      e3 = next_state(3, mode3, int'(sel3), 16'(v3), ordy3, 128'(d3), m3);
      tick();
      m4 = e4;
      m3 = e3;
      chk("rand4_valid", 32'(ov4), 32'(m4.ov));
      chk("rand4_data", 32'(od4), 32'(m4.data));
      chk("rand4_ch", 32'(och4), 32'(m4.ch));
      chk("rand3_valid", 32'(ov3), 32'(m3.ov));
      chk("rand3_data", 32'(od3), 32'(m3.data));
      chk("rand3_ch", 32'(och3), 32'(m3.ch));
`ifdef STREAM_MUX_PARITY_EN
      chk("rand4_par", 32'(par4), 32'(m4.par));
      chk("rand3_par", 32'(par3), 32'(m3.par));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
